// File: rtl/kf_mimo2x2_frame_ctrl_if.sv
// Stream-side bundle for the 2x2 MIMO frame controller: measurement input stream
// and estimate output stream, both valid/ready.
interface kf_mimo2x2_frame_ctrl_if #(
    parameter int WX = 16
);
    logic          s_valid;
    logic          s_ready;
    logic [WX-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [WX-1:0] m_data;
    logic          m_last;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/kf_mimo2x2_frame_ctrl.sv
// Frame controller for the 2x2 MIMO Kalman core: collects 8 measurement words, strobes
// the core, captures its 8 estimates on a valid_all rising edge and streams them back out.
module kf_mimo2x2_frame_ctrl #(
    parameter int WX      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kf_mimo2x2_frame_ctrl_if.slave strm,
    output logic [8*WX-1:0]       z_bus,
    output logic                  en,
    input  logic [8*WX-1:0]       h_bus,
    input  logic                  valid_all,
    output logic                  frame_err,
    output logic                  timeout_err,
    output logic [15:0]           frame_cnt
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FIRE    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [8*WX-1:0] z_q, z_d;
    logic            en_q, en_d;
    logic            prev_va_q, prev_va_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [WX-1:0]   h_q [8];
    logic [WX-1:0]   h_d [8];
    logic            s_ready_q, s_ready_d;
    logic            m_valid_q, m_valid_d;
    logic [WX-1:0]   m_data_q, m_data_d;
    logic            m_last_q, m_last_d;
    logic            frame_err_q, frame_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            s_fire;
    logic            m_fire;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        z_d           = z_q;
        en_d          = 1'b0;
        prev_va_d     = prev_va_q;
        cnt_d         = cnt_q;
        h_d           = h_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        s_fire        = strm.s_valid & s_ready_q;
        m_fire        = m_valid_q & strm.m_ready;

        case (state_q)
            ST_COLLECT: begin
                if (s_fire) begin
                    z_d[idx_q*WX +: WX] = strm.s_data;
                    // The 8th word always completes a frame; a missing s_last is only flagged.
                    if (idx_q == 3'd7) begin
                        state_d     = ST_FIRE;
                        en_d        = 1'b1;
                        frame_err_d = ~strm.s_last;
                        idx_d       = 3'd0;
                    end else if (strm.s_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_FIRE: begin
                prev_va_d = valid_all;
                cnt_d     = 16'd0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                prev_va_d = valid_all;
                // Edge-detect so a valid_all level left over from an earlier frame is not taken.
                if (valid_all && !prev_va_q) begin
                    for (int k = 0; k < 8; k++) begin
                        h_d[k] = h_bus[k*WX +: WX];
                    end
                    idx_d     = 3'd0;
                    m_valid_d = 1'b1;
                    m_data_d  = h_bus[WX-1:0];
                    m_last_d  = 1'b0;
                    state_d   = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == 16'(TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        idx_d         = 3'd0;
                        state_d       = ST_COLLECT;
                    end
                end
            end
            ST_DRAIN: begin
                if (m_fire) begin
                    if (idx_q == 3'd7) begin
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        idx_d       = 3'd0;
                        state_d     = ST_COLLECT;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        m_data_d = h_q[idx_d];
                        m_last_d = (idx_d == 3'd7);
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        s_ready_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            idx_q         <= 3'd0;
            z_q           <= '0;
            en_q          <= 1'b0;
            prev_va_q     <= 1'b0;
            cnt_q         <= 16'd0;
            for (int k = 0; k < 8; k++) begin
                h_q[k] <= '0;
            end
            s_ready_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            z_q           <= z_d;
            en_q          <= en_d;
            prev_va_q     <= prev_va_d;
            cnt_q         <= cnt_d;
            h_q           <= h_d;
            s_ready_q     <= s_ready_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign strm.s_ready = s_ready_q;
    assign strm.m_valid = m_valid_q;
    assign strm.m_data  = m_data_q;
    assign strm.m_last  = m_last_q;
    assign z_bus        = z_q;
    assign en           = en_q;
    assign frame_err    = frame_err_q;
    assign timeout_err  = timeout_err_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
